// File: rtl/dec_scan_seq.sv
// Select/enable sequencer feeding the 3-to-8 decoder: auto-scan with a
// programmable dwell, or one step per req/ack handshake.
module dec_scan_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [SEL_W-1:0]   load_val,
  input  logic               step_req,
  output logic               step_ack,
  output logic [SEL_W-1:0]   w,
  output logic               en,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  localparam logic [SEL_W-1:0] W_MAX = '1;

  state_t             state, state_next;
  logic [DWELL_W-1:0] dwell_cnt, cnt_next, dwell_last;
  logic [SEL_W-1:0]   w_next;
  logic               ack_next, wrap_next, advance;

  // Per-state advance decision first, then stop > load > advance override.
  always_comb begin
    dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    state_next = state;
    w_next     = w;
    cnt_next   = dwell_cnt;
    ack_next   = step_ack;
    wrap_next  = 1'b0;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        ack_next = 1'b0;
        if (start) state_next = mode ? STEP : RUN;
      end
      RUN: begin
        ack_next = 1'b0;
        if (dwell_cnt >= dwell_last) begin
          advance  = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = dwell_cnt + DWELL_W'(1);
        end
      end
      STEP: begin
        // A high ack marks a request already served, so holding req never repeats.
        ack_next = step_req;
        advance  = step_req & ~step_ack;
      end
      default: state_next = IDLE;
    endcase

    if (stop) begin
      state_next = IDLE;
      ack_next   = 1'b0;
      cnt_next   = '0;
    end else if (load) begin
      w_next   = load_val;
      cnt_next = '0;
    end else if (advance) begin
      w_next    = dir ? w - SEL_W'(1) : w + SEL_W'(1);
      wrap_next = dir ? (w == '0) : (w == W_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      dwell_cnt <= '0;
      step_ack  <= 1'b0;
      wrap      <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      w         <= w_next;
      dwell_cnt <= cnt_next;
      step_ack  <= ack_next;
      wrap      <= wrap_next;
      en        <= (state_next != IDLE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: directed vector table, hand sequences for dwell scan
// and async reset, then random traffic against a cycle-level reference model.
module tb_dec_scan_seq;

  logic       clk, rst, start, stop, mode, dir, load, step_req;
  logic [7:0] dwell;
  logic [2:0] load_val;
  logic       step_ack, en, wrap, busy;
  logic [2:0] w;

  int checks = 0;
  int errors = 0;

  bit m_on, m_step, m_ack, m_wrap;
  int m_w, m_cnt;

  typedef struct {
    logic       start, stop, mode, dir;
    logic [7:0] dwell;
    logic       load;
    logic [2:0] load_val;
    logic       step_req;
    logic [2:0] exp_w;
    logic       exp_en, exp_wrap, exp_ack;
  } vec_t;

  vec_t vecs[28];

  dec_scan_seq #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .dwell(dwell), .load(load), .load_val(load_val), .step_req(step_req),
    .step_ack(step_ack), .w(w), .en(en), .wrap(wrap), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic sp, logic md, logic dr, logic [7:0] dw,
                              logic ld, logic [2:0] lv, logic rq,
                              logic [2:0] ew, logic een, logic ewr, logic eak);
    vec_t v;
    v.start = s; v.stop = sp; v.mode = md; v.dir = dr; v.dwell = dw;
    v.load = ld; v.load_val = lv; v.step_req = rq;
    v.exp_w = ew; v.exp_en = een; v.exp_wrap = ewr; v.exp_ack = eak;
    return v;
  endfunction

  task automatic apply_stimulus(logic s, logic sp, logic md, logic dr, logic [7:0] dw,
                                logic ld, logic [2:0] lv, logic rq);
    start = s; stop = sp; mode = md; dir = dr; dwell = dw;
    load = ld; load_val = lv; step_req = rq;
  endtask

  task automatic check_output(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [2:0] ew, logic een, logic ewr, logic eak);
    check_output({tag, ".w"}, w, ew);
    check_output({tag, ".en"}, en, een);
    check_output({tag, ".busy"}, busy, een);
    check_output({tag, ".wrap"}, wrap, ewr);
    check_output({tag, ".ack"}, step_ack, eak);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    m_on = 0; m_step = 0; m_ack = 0; m_wrap = 0; m_w = 0; m_cnt = 0;
  endtask

  // Reference: each value held max(dwell,1) cycles in auto mode, one move per
  // fresh request in step mode; stop beats load beats movement.
  task automatic model_update();
    bit was_on, due;
    int d;
    was_on = m_on;
    due    = 0;
    m_wrap = 0;
    if (stop) begin
      m_on = 0; m_ack = 0; m_cnt = 0;
      return;
    end
    d = (dwell == 0) ? 1 : int'(dwell);
    if (was_on && !m_step) due = (m_cnt >= d - 1);
    if (was_on && m_step) begin
      due   = step_req && !m_ack;
      m_ack = step_req;
    end
    if (!was_on) begin
      m_ack = 0;
      if (start) begin
        m_on = 1;
        m_step = mode;
      end
    end
    if (load) begin
      m_w = int'(load_val);
      m_cnt = 0;
    end else begin
      if (due) begin
        m_wrap = dir ? (m_w == 0) : (m_w == 7);
        m_w    = dir ? (m_w + 7) % 8 : (m_w + 1) % 8;
      end
      if (was_on && !m_step) m_cnt = due ? 0 : m_cnt + 1;
    end
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    vecs[0]  = mk(0,0,0,1,0,1,2,0, 2,0,0,0);
    vecs[1]  = mk(1,0,0,1,0,0,0,0, 2,1,0,0);
    vecs[2]  = mk(0,0,0,1,0,0,0,0, 1,1,0,0);
    vecs[3]  = mk(0,0,0,1,0,0,0,0, 0,1,0,0);
    vecs[4]  = mk(0,0,0,1,0,0,0,0, 7,1,1,0);
    vecs[5]  = mk(0,0,0,1,0,0,0,0, 6,1,0,0);
    vecs[6]  = mk(1,1,0,1,0,0,0,0, 6,0,0,0);
    vecs[7]  = mk(0,0,0,1,0,0,0,0, 6,0,0,0);
    vecs[8]  = mk(1,0,1,0,0,0,0,0, 6,1,0,0);
    vecs[9]  = mk(0,0,0,0,0,0,0,1, 7,1,0,1);
    vecs[10] = mk(0,0,0,0,0,0,0,1, 7,1,0,1);
    vecs[11] = mk(0,0,0,0,0,0,0,1, 7,1,0,1);
    vecs[12] = mk(0,0,0,0,0,0,0,0, 7,1,0,0);
    vecs[13] = mk(0,0,0,0,0,0,0,1, 0,1,1,1);
    vecs[14] = mk(0,0,0,0,0,0,0,1, 0,1,0,1);
    vecs[15] = mk(0,0,0,0,0,0,0,0, 0,1,0,0);
    vecs[16] = mk(0,0,0,0,0,1,5,1, 5,1,0,1);
    vecs[17] = mk(0,0,0,0,0,0,0,0, 5,1,0,0);
    vecs[18] = mk(0,1,0,0,0,0,0,0, 5,0,0,0);
    vecs[19] = mk(0,0,0,0,0,1,3,0, 3,0,0,0);
    vecs[20] = mk(1,0,0,0,3,0,0,0, 3,1,0,0);
    vecs[21] = mk(0,0,0,0,3,0,0,0, 3,1,0,0);
    vecs[22] = mk(0,0,0,0,3,0,0,0, 3,1,0,0);
    vecs[23] = mk(0,0,0,0,3,1,6,0, 6,1,0,0);
    vecs[24] = mk(0,0,0,0,3,0,0,0, 6,1,0,0);
    vecs[25] = mk(0,0,0,0,3,0,0,0, 6,1,0,0);
    vecs[26] = mk(0,0,0,0,3,0,0,0, 7,1,0,0);
    vecs[27] = mk(0,1,0,0,3,0,0,0, 7,0,0,0);

    do_reset();
    for (int i = 0; i < 28; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dir,
                     vecs[i].dwell, vecs[i].load, vecs[i].load_val, vecs[i].step_req);
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_en,
                vecs[i].exp_wrap, vecs[i].exp_ack);
    end

    // Auto scan up with dwell 2: every value held two cycles, wrap on 7->0.
    do_reset();
    apply_stimulus(1, 0, 0, 0, 2, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("scan%0d.w", k), w, 8'((k / 2) % 8));
      check_output($sformatf("scan%0d.wrap", k), wrap, 8'(k == 16));
      check_output($sformatf("scan%0d.en", k), en, 1);
      apply_stimulus(0, 0, 0, 0, 2, 0, 0, 0);
    end

    // Asynchronous reset lands between clock edges.
    do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 1, 5, 0);
    @(posedge clk); @(negedge clk);
    apply_stimulus(1, 0, 0, 0, 3, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    apply_stimulus(0, 0, 0, 0, 3, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    check_all("pre_rst", 5, 1, 0, 0);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom % 8) == 0, ($urandom % 24) == 0, 1'($urandom),
                     1'($urandom), ($urandom % 16 == 0) ? 8'($urandom_range(0, 3)) : dwell,
                     ($urandom % 20) == 0, 3'($urandom),
                     (($urandom % 3) == 0) ? ~step_req : step_req);
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all($sformatf("rand%0d", n), 3'(m_w), m_on, m_wrap, m_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
